// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, x/y counters and registered video_on/sync/strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit completed-frame counter port frame_cnt.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CW        = 10
) (
  input  logic          clk_100MHz,
  input  logic          reset_n,
  input  logic          en,
  output logic          p_tick,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] Y_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic          HS_ON    = (HSYNC_POL != 0);
  localparam logic          VS_ON    = (VSYNC_POL != 0);
  // With no division the very first released clock already ends a slot at (0,0).
  localparam logic          FIRST_TICK = (CLK_DIV == 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          video_on_q, video_on_d;
  logic          hsync_q, hs_act_d;
  logic          vsync_q, vs_act_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          div_last, x_last, y_last, tick;

  always_comb begin
    div_last = (div_q == DIV_LAST);
    x_last   = (x_q == X_LAST);
    y_last   = (y_q == Y_LAST);
    tick     = en && div_last;

    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (en) begin
      div_d = div_last ? '0 : div_q + DW'(1);
    end
    if (tick) begin
      x_d = x_last ? '0 : x_q + CW'(1);
      if (x_last) begin
        y_d = y_last ? '0 : y_q + CW'(1);
      end
    end

    // Decode the upcoming position so the flops line up with x/y.
    video_on_d    = (x_d < X_VIS) && (y_d < Y_VIS);
    hs_act_d      = (x_d >= HS_FIRST) && (x_d <= HS_LAST);
    vs_act_d      = (y_d >= VS_FIRST) && (y_d <= VS_LAST);
    line_start_d  = (div_d == DIV_LAST) && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      video_on_q    <= 1'b1;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      line_start_q  <= FIRST_TICK;
      frame_start_q <= FIRST_TICK;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hs_act_d ? HS_ON : ~HS_ON;
      vsync_q       <= vs_act_d ? VS_ON : ~VS_ON;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (tick && x_last && y_last) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  // Strobes are qualified by en and reset so a stall or reset suppresses them at once.
  assign p_tick      = tick && reset_n;
  assign line_start  = line_start_q && en && reset_n;
  assign frame_start = frame_start_q && en && reset_n;
  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, tiny and medium modes run side by side against an
// arithmetic raster model driven by the count of enabled clocks since reset.
module tb_vga_timing_gen;

  typedef struct {
    int hd, hf, hs, hb, vd, vf, vs, vb, dv, hp, vp;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic en;

  logic       d_pt, d_von, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_pt, s_von, s_hs, s_vs, s_ls, s_fs;
  logic [4:0] s_x, s_y;
  logic       m_pt, m_von, m_hs, m_vs, m_ls, m_fs;
  logic [9:0] m_x, m_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc, m_fc;
`endif

  vga_timing_gen dut (
    .clk_100MHz(clk), .reset_n(reset_n), .en(en), .p_tick(d_pt), .x(d_x), .y(d_y),
    .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .HSYNC_POL(1), .VSYNC_POL(1), .CW(5)
  ) dut_s (
    .clk_100MHz(clk), .reset_n(reset_n), .en(en), .p_tick(s_pt), .x(s_x), .y(s_y),
    .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_timing_gen #(
    .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(3), .HSYNC_POL(0), .VSYNC_POL(0), .CW(10)
  ) dut_m (
    .clk_100MHz(clk), .reset_n(reset_n), .en(en), .p_tick(m_pt), .x(m_x), .y(m_y),
    .video_on(m_von), .hsync(m_hs), .vsync(m_vs), .line_start(m_ls), .frame_start(m_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(m_fc)
`endif
  );

  cfg_t cd, cs, cm;
  int   n = 0;              // enabled clock edges since the last reset edge
  int   cyc = 0;
  int   pass_cnt = 0;
  int   check_cnt = 0;
  int   fail_cnt = 0;
  bit   line_phase = 1'b0;
  int   ls_last = -1, ls_period = 0;
  int   sfs_last = -1, sfs_period = 0;
  int   hs_low_cnt = 0, s_von_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int frames_of(input cfg_t c);
    int ht = c.hd + c.hf + c.hs + c.hb;
    int vt = c.vd + c.vf + c.vs + c.vb;
    return ((n / c.dv) / (ht * vt)) % 65536;
  endfunction

  task automatic model_check(input string nm, input cfg_t c, input logic [31:0] ox,
                             input logic [31:0] oy, input logic op, input logic ovo,
                             input logic ohs, input logic ovs, input logic ols, input logic ofs);
    int ht, vt, slot, ph, ex, ey;
    logic ept, evo, ehs, evs;
    ht   = c.hd + c.hf + c.hs + c.hb;
    vt   = c.vd + c.vf + c.vs + c.vb;
    slot = n / c.dv;
    ph   = n % c.dv;
    ex   = slot % ht;
    ey   = (slot / ht) % vt;
    ept  = en && reset_n && (ph == c.dv - 1);
    evo  = (ex < c.hd) && (ey < c.vd);
    ehs  = (ex >= c.hd + c.hf && ex < c.hd + c.hf + c.hs) ? (c.hp != 0) : (c.hp == 0);
    evs  = (ey >= c.vd + c.vf && ey < c.vd + c.vf + c.vs) ? (c.vp != 0) : (c.vp == 0);
    check({nm, ".x"}, ox, ex);
    check({nm, ".y"}, oy, ey);
    check({nm, ".p_tick"}, op, ept);
    check({nm, ".video_on"}, ovo, evo);
    check({nm, ".hsync"}, ohs, ehs);
    check({nm, ".vsync"}, ovs, evs);
    check({nm, ".line_start"}, ols, ept && ex == 0);
    check({nm, ".frame_start"}, ofs, ept && ex == 0 && ey == 0);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) n = 0;
    else if (en) n++;
    cyc++;
    #1;
    model_check("def", cd, d_x, d_y, d_pt, d_von, d_hs, d_vs, d_ls, d_fs);
    model_check("small", cs, s_x, s_y, s_pt, s_von, s_hs, s_vs, s_ls, s_fs);
    model_check("med", cm, m_x, m_y, m_pt, m_von, m_hs, m_vs, m_ls, m_fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("def.frame_cnt", d_fc, frames_of(cd));
    check("small.frame_cnt", s_fc, frames_of(cs));
    check("med.frame_cnt", m_fc, frames_of(cm));
`endif
    if (line_phase) begin
      if (d_ls) begin
        if (ls_last >= 0) ls_period = cyc - ls_last;
        ls_last = cyc;
      end
      if (s_fs) begin
        if (sfs_last >= 0) sfs_period = cyc - sfs_last;
        sfs_last = cyc;
      end
      if (d_y == 0 && !d_hs) hs_low_cnt++;
      if (n >= 98 && n < 196 && s_von) s_von_cnt++;
    end
  endtask

  initial begin
    logic [9:0] fx, fy;
    logic       fvo, fhs, fvs;
    cd = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 0, 0};
    cs = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 1};
    cm = '{20, 3, 4, 5, 6, 2, 2, 3, 3, 0, 0};

    $display("reset: holding reset_n low for 5 clocks");
    reset_n = 1'b0;
    en      = 1'b1;
    repeat (5) step();
    check("reset.x", d_x, 0);
    check("reset.y", d_y, 0);
    check("reset.video_on", d_von, 1);
    check("reset.hsync", d_hs, 1);
    check("reset.vsync", d_vs, 1);

    $display("release: first tick and two full lines with en high");
    reset_n    = 1'b1;
    line_phase = 1'b1;
    step();
    step();
    step();
    check("first.p_tick", d_pt, 1);
    check("first.frame_start", d_fs, 1);
    step();
    check("first.x_after_tick", d_x, 1);
    repeat (6406) step();
    line_phase = 1'b0;
    check("line_start_period", ls_period, 3200);
    check("hsync_low_clocks_line0", hs_low_cnt, 384);
    check("small.frame_period", sfs_period, 98);
    check("small.video_on_clocks", s_von_cnt, 32);

    $display("stall: dropping en at x=100, div_cnt=2 for 17 clocks");
    for (int i = 0; i < 4000 && !(d_x == 100 && n % 4 == 2); i++) step();
    check("stall.reached", (d_x == 100 && n % 4 == 2), 1);
    fx = d_x; fy = d_y; fvo = d_von; fhs = d_hs; fvs = d_vs;
    en = 1'b0;
    repeat (17) begin
      step();
      check("stall.p_tick", d_pt, 0);
      check("stall.x", d_x, fx);
      check("stall.y", d_y, fy);
      check("stall.outs", {d_von, d_hs, d_vs}, {fvo, fhs, fvs});
    end
    en = 1'b1;
    step();
    check("stall.resume_p_tick", d_pt, 1);
    check("stall.resume_x", d_x, fx);

    $display("random: 5000 clocks of random enable");
    repeat (5000) begin
      en = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("mid-frame reset inside the medium-mode vsync");
    en = 1'b1;
    for (int i = 0; i < 3000 && m_y != 9; i++) step();
    check("midreset.reached", m_y, 9);
    reset_n = 1'b0;
    step();
    check("midreset.x", d_x, 0);
    check("midreset.y", d_y, 0);
    check("midreset.video_on", d_von, 1);
    check("midreset.hsync", d_hs, 1);
    check("midreset.med_vsync", m_vs, 1);
    check("midreset.med_y", m_y, 0);
    check("midreset.p_tick", d_pt, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("midreset.med_frame_cnt", m_fc, 0);
    check("midreset.small_frame_cnt", s_fc, 0);
`endif
    reset_n = 1'b1;
    repeat (400) begin
      en = ($urandom_range(0, 4) != 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: divides the system clock into a pixel-tick strobe and generates the horizontal and vertical pixel counters, display-enable and sync outputs for any VESA-style mode. It sits between the board clock and the pixel/object renderers (paddles, ball, score text), which consume `x`, `y`, `video_on` and `p_tick`. Relative to the fixed 640x480 generator, it adds:
- Configurable porch, sync and divider values.
- Selectable sync polarity.
- Zero-skew registered outputs.
- A run enable.
- Line and frame strobes.
- An optional frame counter.

## Interface
Parameters:
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, pixels.
- `H_SYNC`, 96: horizontal sync width, pixels.
- `H_BACK`, 48: horizontal back porch, pixels.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, lines.
- `V_SYNC`, 2: vertical sync width, lines.
- `V_BACK`, 33: vertical back porch, lines.
- `CLK_DIV`, 4: system clocks per pixel, ≥1.
- `HSYNC_POL`, 0: active level of `hsync` (0 = active-low).
- `VSYNC_POL`, 0: active level of `vsync`.
- `CW`, 10: width of `x`/`y`. Must hold `H_TOTAL-1` and `V_TOTAL-1`.

Ports:
- `clk_100MHz`, in, 1: system clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `en`, in, 1: run enable. When low, all state freezes.
- `p_tick`, out, 1: pixel tick, high on the last clock of each pixel slot.
- `x`, out, CW: horizontal count, 0..H_TOTAL-1.
- `y`, out, CW: vertical count, 0..V_TOTAL-1.
- `video_on`, out, 1: pixel `(x,y)` is in the visible area.
- `hsync`, out, 1: horizontal sync, polarity per `HSYNC_POL`.
- `vsync`, out, 1: vertical sync, polarity per `VSYNC_POL`.
- `line_start`, out, 1: high with `p_tick` when `x==0`.
- `frame_start`, out, 1: high with `p_tick` when `x==0 && y==0`.
- `frame_cnt`, out, 16: completed-frame counter. Present only with `VGA_TIMING_FRAME_CNT_EN`.

The clock is `clk_100MHz`. The reset is `reset_n`: synchronous and active-low. No other clocks or resets.

## Operation
- Derived totals: `H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK` (800); `V_TOTAL` likewise (525).
- Line order: display, front porch, sync, back porch.
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 while `en`=1, then wraps.
  - `p_tick` = (`div_cnt==CLK_DIV-1`) && `en`.
  - With `CLK_DIV`=1, `p_tick` equals `en`.
- Horizontal counter: on each `p_tick` edge, `x` increments. At `H_TOTAL-1` it wraps to 0.
- Vertical counter:
  - `y` increments only on a `p_tick` edge where `x==H_TOTAL-1`.
  - At `V_TOTAL-1` (with `x` also at its last value) it wraps to 0.
- `video_on` = `x<H_DISPLAY && y<V_DISPLAY`.
- `hsync` is active for `H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1` (656..751 by default). Otherwise it is at the inactive level.
- `vsync` is active for `V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1` (490..491 by default).
- `video_on`, `hsync` and `vsync` are flops loaded by look-ahead decode of the next `(x,y)`. They change on the same edge as `x`/`y`, with no combinational path from counters to outputs.
- `line_start`/`frame_start` are flop outputs, computed by look-ahead from the next `div_cnt`, `x` and `y`.
- `en` low:
  - `div_cnt`, `x`, `y` and all decoded outputs hold their values.
  - `p_tick`, `line_start` and `frame_start` are 0.
  - When `en` rises, the divider resumes from the held `div_cnt`.
- A `reset_n` low mid-frame returns the block to the reset state on the next edge, regardless of `en`.

## Timing
- Reset values (`reset_n` sampled low):
  - `div_cnt`=0, `x`=0, `y`=0, `p_tick`=0.
  - `video_on`=1, because (0,0) is visible.
  - `hsync`=!HSYNC_POL, `vsync`=!VSYNC_POL.
  - `line_start`=0, `frame_start`=0, `frame_cnt`=0.
- After release with `en`=1:
  - The first `p_tick` is on clock `CLK_DIV`, counting the first released clock as 1.
  - `frame_start` and `line_start` are high in that same cycle.
  - `x` becomes 1 on the following edge.
- Each pixel slot lasts exactly CLK_DIV clocks. A line is `H_TOTAL*CLK_DIV` clocks; a frame is `H_TOTAL*V_TOTAL*CLK_DIV` clocks (1,680,000 by default).
- Latency from counter change to `video_on`/`hsync`/`vsync`: 0 cycles (aligned).
- Simultaneous wrap: at `(H_TOTAL-1, V_TOTAL-1)` a `p_tick` edge sets `x=0` and `y=0` together.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists.
  - It increments by 1 on each `p_tick` edge where `(x,y)=(H_TOTAL-1,V_TOTAL-1)`, i.e. coincident with the next `frame_start`'s slot beginning.
  - It wraps 0xFFFF→0 and is cleared by reset.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset/first tick, defaults: hold `reset_n`=0 for 5 clocks and check `x=0`, `y=0`, `video_on=1`, `hsync=vsync=1`. Then release and check the first `p_tick` and `frame_start` on clock 4, and `x=1` after that edge.
- Line timing, defaults: check `hsync` low for exactly 96 slots (`x` 656..751), `video_on` low from `x`=640, and `line_start` period = 3200 clocks.
- Frame timing, defaults: check `vsync` low only for `y` 490..491, the `frame_start` period = 1,680,000 clocks, and the wrap (799,524)→(0,0) on one edge.
- Small mode: H=8/2/2/2, V=4/1/1/1, CLK_DIV=1, HSYNC_POL=VSYNC_POL=1. Check that `p_tick` is constantly 1, `hsync` is high at `x`=10..11, the frame is 14×7=98 clocks, and `video_on` is high for exactly 32 clocks per frame.
- Enable stall: drop `en` at `x`=100 mid-slot (`div_cnt`=2) for 17 clocks. Check no `p_tick`, all outputs frozen, and that the next `p_tick` comes 1 clock after `en` returns.
- Mid-frame reset and frame counter (`VGA_TIMING_FRAME_CNT_EN`): run 3 frames and check `frame_cnt`=3. Then assert `reset_n` at `y`=200 and check all outputs return to reset values on the next edge, with `frame_cnt`=0.
